// File: rtl/spi_slave.sv
// spi_slave: SPI slave for all four CPOL/CPHA modes, MSB-first frames.
// Define SPI_SLAVE_MULTIBYTE_EN to chain frames while ss stays low.
module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sck,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // [0],[1] synchronise; [2] is the history flop for edge detection
    logic [2:0] sck_sync_q, sck_sync_d;
    logic [2:0] ss_sync_q, ss_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    // vld_q[k] set once stage k holds a real pin sample after reset
    logic [2:0] vld_q, vld_d;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;

    logic sck_s, sck_chg, lead, trail;
    logic ss_s, ss_fall, ss_rise, mosi_s;
    logic sample_edge, drive_edge;

    // Next values of the synchroniser chains
    always_comb begin
        sck_sync_d  = {sck_sync_q[1:0], sck};
        ss_sync_d   = {ss_sync_q[1:0], ss};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        vld_d       = {vld_q[1:0], 1'b1};
    end

    // Synchroniser flops; ss chain idles high so reset looks deselected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            vld_q       <= vld_d;
        end
    end

    // Edge classification relative to the idle clock level
    always_comb begin
        sck_s       = sck_sync_q[1];
        sck_chg     = sck_sync_q[1] ^ sck_sync_q[2];
        lead        = sck_chg & (sck_s != cpol);
        trail       = sck_chg & (sck_s == cpol);
        ss_s        = ss_sync_q[1];
        // a fall only counts if ss was genuinely seen high since reset
        ss_fall     = ~ss_s & ss_sync_q[2] & vld_q[2];
        ss_rise     = ss_s & ~ss_sync_q[2];
        mosi_s      = mosi_sync_q[1];
        sample_edge = cpha ? trail : lead;
        drive_edge  = cpha ? lead : trail;
    end

    // Frame FSM next-state and datapath
    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        data_out_d = data_out_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (ss_fall) begin
                    state_d = ACTIVE;
                    busy_d  = 1'b1;
                    rx_sr_d = '0;
                    tx_sr_d = tx_data;
                    if (!cpha) begin
                        miso_d  = tx_data[DATA_WIDTH-1];
                        tx_sr_d = tx_data << 1;
                    end
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    if (drive_edge) begin
                        miso_d  = tx_sr_q[DATA_WIDTH-1];
                        tx_sr_d = tx_sr_q << 1;
                    end
                    if (sample_edge) begin
                        rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
                        if (cnt_q == LAST) begin
                            data_out_d = rx_sr_d;
                            rx_valid_d = 1'b1;
                            cnt_d      = '0;
`ifdef SPI_SLAVE_MULTIBYTE_EN
                            // next drive edge emits the new MSB
                            tx_sr_d    = tx_data;
`else
                            state_d    = DONE;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (ss_s) begin
            miso_d = 1'b0;
        end
    end

    // Frame FSM and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            data_out_q <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            data_out_q <= data_out_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign miso     = miso_q;
    assign data_out = data_out_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed vector bench for spi_slave.
// Honours SPI_SLAVE_MULTIBYTE_EN when building expectations.
module tb_spi_slave;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpol;
    logic       cpha;
    logic       sck;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    logic [7:0] w_last = 8'h00;
    logic [7:0] w_prev = 8'h00;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] mo;
        logic [7:0] tx;
        logic [7:0] exp_do;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[7];

    spi_slave #(.DATA_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .cpol(cpol),
        .cpha(cpha),
        .sck(sck),
        .ss(ss),
        .mosi(mosi),
        .miso(miso),
        .tx_data(tx_data),
        .data_out(data_out),
        .rx_valid(rx_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && rx_valid) begin
            pulses = pulses + 1;
            w_prev = w_last;
            w_last = data_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setup(input logic pol, input logic pha,
                         input logic [7:0] tx);
        cpol    = pol;
        cpha    = pha;
        sck     = pol;
        tx_data = tx;
        tick(8);
    endtask

    task automatic sel();
        ss = 1'b0;
        tick(8);
    endtask

    task automatic desel();
        tick(HALF);
        ss = 1'b1;
        tick(8);
    endtask

    task automatic bits(input logic [7:0] m, input int n,
                        output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                mosi = m[7-i];
                tick(HALF);
                r = {r[6:0], miso};
                sck = ~cpol;
                tick(HALF);
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = m[7-i];
                tick(HALF);
                r = {r[6:0], miso};
                sck = cpol;
                tick(HALF);
            end
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] ra;
        logic [7:0] rb;
        int base;

        vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[2] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{1'b1, 1'b1, 8'h69, 8'h96, 8'h69, 8'h96};
        vecs[6] = '{1'b0, 1'b1, 8'h55, 8'hAA, 8'h55, 8'hAA};

        rst = 1'b0;
        cpol = 1'b0;
        cpha = 1'b0;
        sck = 1'b0;
        ss = 1'b1;
        mosi = 1'b0;
        tx_data = 8'h00;
        tick(3);
        #1;
        chk("rst_miso", miso, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(8);

        for (int v = 0; v < 7; v++) begin
            setup(vecs[v].cpol, vecs[v].cpha, vecs[v].tx);
            base = pulses;
            sel();
            tx_data = ~vecs[v].tx;
            bits(vecs[v].mo, 8, r);
            chk($sformatf("v%0d_busy_in", v), busy, 1);
            desel();
            chk($sformatf("v%0d_busy_out", v), busy, 0);
            chk($sformatf("v%0d_miso_idle", v), miso, 0);
            chk($sformatf("v%0d_data_out", v), data_out, vecs[v].exp_do);
            chk($sformatf("v%0d_master_rx", v), r, vecs[v].exp_rx);
            chk($sformatf("v%0d_pulses", v), pulses - base, 1);
        end

        // abort after 4 bits in mode 1, data_out holds 0x55
        setup(1'b0, 1'b1, 8'h99);
        base = pulses;
        sel();
        bits(8'hF0, 4, r);
        desel();
        chk("abort_pulses", pulses - base, 0);
        chk("abort_data_out", data_out, 8'h55);
        chk("abort_busy", busy, 0);
        base = pulses;
        sel();
        tx_data = 8'h33;
        bits(8'h0F, 8, r);
        desel();
        chk("post_abort_data", data_out, 8'h0F);
        chk("post_abort_rx", r, 8'h99);
        chk("post_abort_pulses", pulses - base, 1);

        // reset mid-frame in mode 2
        setup(1'b1, 1'b0, 8'hFF);
        sel();
        bits(8'hC3, 4, r);
        chk("pre_rst_miso", miso, 1);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("midrst_miso", miso, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_busy", busy, 0);
        tick(2);
        rst = 1'b1;
        tick(10);
        base = pulses;
        chk("rel_busy", busy, 0);
        bits(8'h3C, 4, r);
        chk("rel_idle_busy", busy, 0);
        chk("rel_idle_pulses", pulses - base, 0);
        desel();
        tx_data = 8'h5A;
        tick(4);
        sel();
        bits(8'hC3, 8, r);
        desel();
        chk("rst_frame_data", data_out, 8'hC3);
        chk("rst_frame_rx", r, 8'h5A);
        chk("rst_frame_pulses", pulses - base, 1);

        // two frames with ss held low in mode 0
        setup(1'b0, 1'b0, 8'hAB);
        base = pulses;
        sel();
        bits(8'h12, 4, ra);
        tx_data = 8'hCD;
        bits(8'h20, 4, rb);
        bits(8'h34, 8, r);
        desel();
        chk("mb_first_rx", {ra[3:0], rb[3:0]}, 8'hAB);
`ifdef SPI_SLAVE_MULTIBYTE_EN
        chk("mb_pulses", pulses - base, 2);
        chk("mb_word0", w_prev, 8'h12);
        chk("mb_word1", w_last, 8'h34);
        chk("mb_data_out", data_out, 8'h34);
        chk("mb_second_rx", r, 8'hCD);
`else
        chk("mb_pulses", pulses - base, 1);
        chk("mb_word0", w_last, 8'h12);
        chk("mb_data_out", data_out, 8'h12);
`endif
        chk("mb_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
